// File: rtl/home_status_reporter_pkg.sv
// home_status_reporter_pkg: report bytes, queue default and transmit FSM encodings.
// The PARITY state exists only when HOME_REPORTER_PARITY_EN is defined.
package home_status_reporter_pkg;

    localparam logic [7:0] REPORT_ALERT      = 8'hE1;
    localparam logic [7:0] REPORT_WARNING    = 8'hD1;
    localparam int         REPORT_FIFO_DEPTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
`ifdef HOME_REPORTER_PARITY_EN
        ST_PARITY = 3'd3,
`endif
        ST_STOP   = 3'd4
    } tx_state_t;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/home_status_reporter_uart_tx_core.sv
// uart_tx_core: bit-period counter, shift register and frame FSM (8N1, or 8E1 when
// HOME_REPORTER_PARITY_EN is defined); ready is high in IDLE and on the last STOP cycle.
module uart_tx_core
    import home_status_reporter_pkg::*;
#(
    parameter int BIT_CYCLES = 10416
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] data,
    input  logic       start,
    output logic       ready,
    output logic       tx
);

    localparam int CW = cnt_width(BIT_CYCLES);

    tx_state_t   state, next_state;
    logic [CW-1:0] cnt;
    logic [2:0]  idx;
    logic [7:0]  shreg;
    logic        bit_end, take;
`ifdef HOME_REPORTER_PARITY_EN
    logic        par;
`endif

    assign bit_end = cnt == CW'(BIT_CYCLES - 1);
    assign take    = start & ready;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= ST_IDLE;
            cnt   <= '0;
            idx   <= '0;
            shreg <= '0;
`ifdef HOME_REPORTER_PARITY_EN
            par   <= 1'b0;
`endif
        end else begin
            state <= next_state;
            cnt   <= (state == ST_IDLE || bit_end) ? '0 : cnt + CW'(1);
            if (take) begin
                shreg <= data;
                idx   <= '0;
`ifdef HOME_REPORTER_PARITY_EN
                par   <= ^data;
`endif
            end else if (state == ST_DATA && bit_end) begin
                shreg <= shreg >> 1;
                idx   <= idx + 3'd1;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE:   if (start) next_state = ST_START;
            ST_START:  if (bit_end) next_state = ST_DATA;
`ifdef HOME_REPORTER_PARITY_EN
            ST_DATA:   if (bit_end && idx == 3'd7) next_state = ST_PARITY;
            ST_PARITY: if (bit_end) next_state = ST_STOP;
`else
            ST_DATA:   if (bit_end && idx == 3'd7) next_state = ST_STOP;
`endif
            // Back-to-back frames: a queued byte skips IDLE entirely.
            ST_STOP:   if (bit_end) next_state = start ? ST_START : ST_IDLE;
            default:   next_state = ST_IDLE;
        endcase
    end

    always_comb begin
        ready = state == ST_IDLE || (state == ST_STOP && bit_end);
`ifdef HOME_REPORTER_PARITY_EN
        tx = state == ST_START  ? 1'b0 :
             state == ST_DATA   ? shreg[0] :
             state == ST_PARITY ? par : 1'b1;
`else
        tx = state == ST_START ? 1'b0 :
             state == ST_DATA  ? shreg[0] : 1'b1;
`endif
    end

endmodule

// File: rtl/home_status_reporter.sv
// home_status_reporter: alert/warning edge detectors, priority writer and report FIFO feeding
// uart_tx_core; define HOME_REPORTER_PARITY_EN for 8E1 framing.
module home_status_reporter
    import home_status_reporter_pkg::*;
#(
    parameter int CLOCK_RATE = 100_000_000,
    parameter int BAUD_RATE  = 9600,
    parameter int FIFO_DEPTH = REPORT_FIFO_DEPTH
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       alert_i,
    input  logic       warning_i,
    input  logic       ack_valid_i,
    input  logic [7:0] ack_byte_i,
    output logic       ack_ready_o,
    output logic       tx,
    output logic       busy_o
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic [7:0] wr_data;
    logic alert_q, warning_q, pend_alert, pend_warn;
    logic alert_edge, warning_edge, empty, full, pop, push, can_write, core_ready, frame_active;

    assign alert_edge   = alert_i & ~alert_q;
    assign warning_edge = warning_i & ~warning_q;
    assign empty        = wr_ptr == rd_ptr;
    assign full         = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop          = core_ready & ~empty;
    assign can_write    = ~full | pop;
    // Fresh edges count as pending so an ack offered alongside them queues behind the reports.
    assign ack_ready_o  = ~reset & can_write & ~pend_alert & ~pend_warn & ~alert_edge & ~warning_edge;
    assign push         = can_write & (pend_alert | pend_warn | ack_valid_i & ack_ready_o);
    assign wr_data      = pend_alert ? REPORT_ALERT : pend_warn ? REPORT_WARNING : ack_byte_i;
    assign busy_o       = frame_active | ~empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            alert_q      <= alert_i;
            warning_q    <= warning_i;
            pend_alert   <= 1'b0;
            pend_warn    <= 1'b0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            frame_active <= 1'b0;
        end else begin
            alert_q      <= alert_i;
            warning_q    <= warning_i;
            pend_alert   <= alert_edge | (pend_alert & ~can_write);
            pend_warn    <= warning_edge | (pend_warn & ~(can_write & ~pend_alert));
            if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
            if (pop) rd_ptr <= rd_ptr + (AW+1)'(1);
            frame_active <= pop | (frame_active & ~core_ready);
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= wr_data;
    end

    uart_tx_core #(
        .BIT_CYCLES(CLOCK_RATE / BAUD_RATE)
    ) u_core (
        .clk  (clk),
        .reset(reset),
        .data (mem[rd_ptr[AW-1:0]]),
        .start(pop),
        .ready(core_ready),
        .tx   (tx)
    );

endmodule

// File: tb/tb_home_status_reporter.sv
// tb_home_status_reporter: directed scenarios with a 16-cycle bit period; inputs driven and
// outputs sampled on the falling clock edge.
module tb_home_status_reporter;

    localparam int BC = 16;
`ifdef HOME_REPORTER_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       alert_i = 1'b0;
    logic       warning_i = 1'b0;
    logic       ack_valid_i = 1'b0;
    logic [7:0] ack_byte_i = 8'h00;
    logic       ack_ready_o, tx, busy_o;
    logic       last_par = 1'b0;
    int         checks = 0;
    int         failures = 0;

    always #5 clk = ~clk;

    home_status_reporter #(
        .CLOCK_RATE(160),
        .BAUD_RATE (10),
        .FIFO_DEPTH(8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .alert_i    (alert_i),
        .warning_i  (warning_i),
        .ack_valid_i(ack_valid_i),
        .ack_byte_i (ack_byte_i),
        .ack_ready_o(ack_ready_o),
        .tx         (tx),
        .busy_o     (busy_o)
    );

    // Waits for a start bit, then samples every bit at its centre.
    task automatic rx_frame(output logic [7:0] b, output int waited);
        b = 'x;
        waited = 0;
        while (tx !== 1'b0 && waited < 2000) begin
            @(negedge clk);
            waited++;
        end
        checks++;
        if (tx !== 1'b0) begin
            failures++;
            $display("FAIL rx_timeout: tx=%b after %0d cycles, expected 0", tx, waited);
            return;
        end
        repeat (BC/2) @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin failures++; $display("FAIL start_bit: tx=%b expected 0", tx); end
        for (int i = 0; i < 8; i++) begin
            repeat (BC) @(negedge clk);
            b[i] = tx;
        end
`ifdef HOME_REPORTER_PARITY_EN
        repeat (BC) @(negedge clk);
        last_par = tx;
        checks++;
        if (last_par !== ^b) begin failures++; $display("FAIL parity_bit: got %b expected %b", last_par, ^b); end
`endif
        repeat (BC) @(negedge clk);
        checks++;
        if (tx !== 1'b1) begin failures++; $display("FAIL stop_bit: tx=%b expected 1", tx); end
    endtask

    task automatic wait_idle;
        int n = 0;
        while (busy_o !== 1'b0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL idle_timeout: busy_o=%b expected 0", busy_o); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset;
        int lows = 0;
        reset = 1'b1;
        alert_i = 1'b1;
        repeat (3) @(negedge clk);
        checks += 3;
        if (tx !== 1'b1) begin failures++; $display("FAIL reset_tx: got %b expected 1", tx); end
        if (ack_ready_o !== 1'b0) begin failures++; $display("FAIL reset_ack_ready: got %b expected 0", ack_ready_o); end
        if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        reset = 1'b0;
        @(negedge clk);
        checks += 2;
        if (ack_ready_o !== 1'b1) begin failures++; $display("FAIL post_reset_ack_ready: got %b expected 1", ack_ready_o); end
        if (busy_o !== 1'b0) begin failures++; $display("FAIL post_reset_busy: got %b expected 0", busy_o); end
        repeat (3*BC) begin
            @(negedge clk);
            if (tx !== 1'b1) lows++;
        end
        checks++;
        if (lows != 0) begin failures++; $display("FAIL alert_high_at_reset: %0d low cycles, expected 0", lows); end
        alert_i = 1'b0;
        repeat (4) @(negedge clk);
    endtask

    task automatic test_ack_frame(input logic [7:0] v);
        logic [7:0] b;
        int w;
        wait_idle();
        ack_byte_i = v;
        ack_valid_i = 1'b1;
        #1;
        checks++;
        if (ack_ready_o !== 1'b1) begin failures++; $display("FAIL ack_ready_idle: got %b expected 1", ack_ready_o); end
        @(negedge clk);
        ack_valid_i = 1'b0;
        checks++;
        if (tx !== 1'b1) begin failures++; $display("FAIL tx_before_start: got %b expected 1", tx); end
        @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin failures++; $display("FAIL tx_fall_latency: got %b expected 0", tx); end
        rx_frame(b, w);
        checks++;
        if (b !== v) begin failures++; $display("FAIL ack_byte: got %h expected %h", b, v); end
        repeat (BC/2 - 1) @(negedge clk);
        checks++;
        if (busy_o !== 1'b1) begin failures++; $display("FAIL busy_last_stop: got %b expected 1", busy_o); end
        @(negedge clk);
        checks += 2;
        if (busy_o !== 1'b0) begin failures++; $display("FAIL busy_after_frame: got %b expected 0", busy_o); end
        if (tx !== 1'b1) begin failures++; $display("FAIL tx_after_frame: got %b expected 1", tx); end
    endtask

    task automatic test_simultaneous;
        logic [7:0] exp [3];
        int cyc = 0;
        exp[0] = 8'hE1;
        exp[1] = 8'hD1;
        exp[2] = 8'hC7;
        wait_idle();
        alert_i = 1'b1;
        warning_i = 1'b1;
        ack_byte_i = 8'hC7;
        ack_valid_i = 1'b1;
        fork
            begin
                logic [7:0] b;
                int w;
                for (int i = 0; i < 3; i++) begin
                    rx_frame(b, w);
                    checks++;
                    if (b !== exp[i]) begin failures++; $display("FAIL simul_order[%0d]: got %h expected %h", i, b, exp[i]); end
                    if (i > 0) begin
                        checks++;
                        if (w != BC/2) begin failures++; $display("FAIL simul_gap[%0d]: got %0d expected %0d", i, w, BC/2); end
                    end
                end
            end
            begin
                #1;
                while (ack_ready_o !== 1'b1 && cyc < 100) begin
                    @(negedge clk);
                    cyc++;
                    #1;
                end
                @(negedge clk);
                ack_valid_i = 1'b0;
                checks++;
                if (cyc < 2 || cyc > 10) begin failures++; $display("FAIL simul_ack_delay: got %0d cycles, expected 2..10", cyc); end
            end
        join
        alert_i = 1'b0;
        warning_i = 1'b0;
    endtask

    task automatic test_fifo_full;
        int k = 0;
        logic saw_block = 1'b0;
        wait_idle();
        fork
            begin
                logic [7:0] b;
                int w;
                for (int i = 0; i < 12; i++) begin
                    rx_frame(b, w);
                    checks++;
                    if (b !== 8'(i)) begin failures++; $display("FAIL full_order[%0d]: got %h expected %h", i, b, 8'(i)); end
                end
            end
            begin
                int cyc = 0;
                while (k < 12 && cyc < 4000) begin
                    ack_byte_i = 8'(k);
                    ack_valid_i = 1'b1;
                    #1;
                    if (ack_ready_o === 1'b1) k++;
                    else saw_block = 1'b1;
                    @(negedge clk);
                    cyc++;
                end
                ack_valid_i = 1'b0;
            end
        join
        checks += 2;
        if (k != 12) begin failures++; $display("FAIL full_accepted: got %0d expected 12", k); end
        if (saw_block !== 1'b1) begin failures++; $display("FAIL full_backpressure: got %b expected 1", saw_block); end
    endtask

    task automatic test_alert_merge;
        int n = 0;
        wait_idle();
        fork
            begin
                logic [7:0] b, e;
                int w;
                for (int i = 0; i < 10; i++) begin
                    e = (i < 9) ? 8'(8'h10 + i) : 8'hE1;
                    rx_frame(b, w);
                    checks++;
                    if (b !== e) begin failures++; $display("FAIL merge_order[%0d]: got %h expected %h", i, b, e); end
                end
                repeat (BC/2) @(negedge clk);
                checks++;
                if (busy_o !== 1'b0) begin failures++; $display("FAIL merge_extra_report: busy_o=%b expected 0", busy_o); end
            end
            begin
                while (n < 20) begin
                    ack_byte_i = 8'(8'h10 + n);
                    ack_valid_i = 1'b1;
                    #1;
                    if (ack_ready_o !== 1'b1) break;
                    @(negedge clk);
                    n++;
                end
                ack_valid_i = 1'b0;
                checks++;
                if (n != 9) begin failures++; $display("FAIL merge_fill_count: got %0d expected 9", n); end
                repeat (3) begin
                    @(negedge clk);
                    alert_i = 1'b1;
                    @(negedge clk);
                    alert_i = 1'b0;
                end
            end
        join
    endtask

    task automatic test_reset_mid_frame;
        int lows = 0;
        wait_idle();
        ack_byte_i = 8'h45;
        ack_valid_i = 1'b1;
        #1;
        checks++;
        if (ack_ready_o !== 1'b1) begin failures++; $display("FAIL midreset_ack_ready: got %b expected 1", ack_ready_o); end
        @(negedge clk);
        ack_byte_i = 8'h66;
        @(negedge clk);
        ack_valid_i = 1'b0;
        checks++;
        if (tx !== 1'b0) begin failures++; $display("FAIL midreset_start: got %b expected 0", tx); end
        repeat (BC*5 + BC/2) @(negedge clk);
        checks++;
        if (tx !== 1'b0) begin failures++; $display("FAIL midreset_bit4: got %b expected 0", tx); end
        reset = 1'b1;
        @(negedge clk);
        checks += 3;
        if (tx !== 1'b1) begin failures++; $display("FAIL midreset_tx: got %b expected 1", tx); end
        if (busy_o !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b expected 0", busy_o); end
        if (ack_ready_o !== 1'b0) begin failures++; $display("FAIL midreset_ack_low: got %b expected 0", ack_ready_o); end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (ack_ready_o !== 1'b1) begin failures++; $display("FAIL midreset_ack_after: got %b expected 1", ack_ready_o); end
        repeat (2*NBITS*BC) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy_o !== 1'b0) lows++;
        end
        checks++;
        if (lows != 0) begin failures++; $display("FAIL midreset_discard: %0d active cycles, expected 0", lows); end
    endtask

`ifdef HOME_REPORTER_PARITY_EN
    task automatic test_parity;
        test_ack_frame(8'h07);
        checks++;
        if (last_par !== 1'b1) begin failures++; $display("FAIL parity_07: got %b expected 1", last_par); end
    endtask
`endif

    initial begin
        test_reset();
        test_ack_frame(8'hA3);
        test_simultaneous();
        test_fifo_full();
        test_alert_merge();
        test_reset_mid_frame();
`ifdef HOME_REPORTER_PARITY_EN
        test_parity();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
